// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory path: arbiter FSM states and cacheline width.
package rv32i_types;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line requests onto one cacheline adaptor; ARB_ROUND_ROBIN_EN selects round-robin contention.
// Latency: one-cycle grant from IDLE; response forwarded combinationally; at least one IDLE cycle between transactions.
// Backpressure: a request stays pending until its SERVE state sees pmem_resp; the losing cache simply waits.
module cache_arbiter #(
    parameter int LINE_W = rv32i_types::LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    import rv32i_types::*;

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              i_req, d_req, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
    // 1 = dcache was granted last, 0 = icache
    logic              last_q, last_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_req & (~i_req | ~last_q);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
                    // a simultaneous read+write is treated as a writeback
                    write_d = d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = 1'b1;
`endif
                end else if (i_req) begin
                    state_d = SERVE_I;
                    addr_d  = i_pmem_address;
                    wdata_d = '0;
                    write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = 1'b0;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are forced quiet while rst is high, even before the reset edge lands
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = pmem_rdata;
        d_pmem_rdata = pmem_rdata;
        if (!rst) begin
            pmem_address = addr_q;
            pmem_wdata   = wdata_q;
            case (state_q)
                SERVE_I: begin
                    pmem_read   = 1'b1;
                    i_pmem_resp = pmem_resp;
                end
                SERVE_D: begin
                    pmem_read   = ~write_q;
                    pmem_write  = write_q;
                    d_pmem_resp = pmem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule
